// File: rtl/half_bridge_driver_pkg.sv
// Shared types for the half-bridge gate driver.
//   mode_e      : per-phase drive mode as presented on the mode input
//   leg_state_e : per-leg dead-time FSM state
//   demand_e    : what the PWM decode wants a leg to do this cycle
//   decode_demand / state_for : small helpers used by top and leg FSM
package half_bridge_pkg;

    typedef enum logic [1:0] {
        MODE_PWM       = 2'd0,
        MODE_HIGH_ONLY = 2'd1,
        MODE_BRAKE     = 2'd2,
        MODE_COAST     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DEAD = 2'd3
    } leg_state_e;

    typedef enum logic [1:0] {
        DEM_OFF  = 2'd0,
        DEM_HIGH = 2'd1,
        DEM_LOW  = 2'd2
    } demand_e;

    // below_duty is (cnt < act_duty); force_off covers high_z and enable=0.
    function automatic demand_e decode_demand(input mode_e mode, input logic below_duty,
                                              input logic force_off);
        demand_e d;
        d = DEM_OFF;
        if (!force_off) begin
            case (mode)
                MODE_PWM:       d = below_duty ? DEM_HIGH : DEM_LOW;
                MODE_HIGH_ONLY: d = below_duty ? DEM_HIGH : DEM_OFF;
                MODE_BRAKE:     d = DEM_LOW;
                default:        d = DEM_OFF;
            endcase
        end
        return d;
    endfunction

    function automatic leg_state_e state_for(input demand_e d);
        case (d)
            DEM_HIGH: return ST_HIGH;
            DEM_LOW:  return ST_LOW;
            default:  return ST_OFF;
        endcase
    endfunction

endpackage

// File: rtl/half_bridge_driver_if.sv
// Control/gate bundle between the commutation logic (master) and the
// gate driver (slave).
//   enable_i       : global run
//   duty_i         : per-phase duty, phase i at [i*DUTY_WIDTH +: DUTY_WIDTH]
//   mode_i         : per-phase 2-bit mode, phase i at [i*2 +: 2]
//   high_z_i       : per-phase immediate off
//   pwm_high_o/low : registered gate outputs
//   period_start_o : one-cycle pulse at the start of each PWM period
interface half_bridge_driver_if #(
    parameter int NUM_PHASES = 3,
    parameter int DUTY_WIDTH = 9
);
    logic                             enable_i;
    logic [NUM_PHASES*DUTY_WIDTH-1:0] duty_i;
    logic [NUM_PHASES*2-1:0]          mode_i;
    logic [NUM_PHASES-1:0]            high_z_i;
    logic [NUM_PHASES-1:0]            pwm_high_o;
    logic [NUM_PHASES-1:0]            pwm_low_o;
    logic                             period_start_o;

    modport master (
        output enable_i, duty_i, mode_i, high_z_i,
        input  pwm_high_o, pwm_low_o, period_start_o
    );

    modport slave (
        input  enable_i, duty_i, mode_i, high_z_i,
        output pwm_high_o, pwm_low_o, period_start_o
    );
endinterface

// File: rtl/half_bridge_driver_dead_time.sv
// One bridge leg: OFF/HIGH/LOW/DEAD FSM with dead-time counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   demand_i     : requested drive for this cycle
//   pwm_high_o   : high-side gate, registered
//   pwm_low_o    : low-side gate, registered
// Leaving HIGH or LOW always passes through DEAD for DEAD_TIME cycles with
// both gates off; demand is only re-sampled when the timer expires.
module dead_time_fsm
    import half_bridge_pkg::*;
#(
    parameter int DEAD_TIME = 8
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  demand_e demand_i,
    output logic    pwm_high_o,
    output logic    pwm_low_o
);
    localparam int TW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [TW-1:0] DT_LOAD = TW'(DEAD_TIME - 1);

    leg_state_e    state_q;
    logic [TW-1:0] dtimer_q;
    logic          pwm_high_q, pwm_low_q;

    // Outputs are registered alongside the state so they always equal the
    // decode of the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_OFF;
            dtimer_q   <= '0;
            pwm_high_q <= 1'b0;
            pwm_low_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_q    <= state_for(demand_i);
                    pwm_high_q <= (demand_i == DEM_HIGH);
                    pwm_low_q  <= (demand_i == DEM_LOW);
                end
                ST_HIGH: begin
                    if (demand_i != DEM_HIGH) begin
                        state_q    <= ST_DEAD;
                        dtimer_q   <= DT_LOAD;
                        pwm_high_q <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (demand_i != DEM_LOW) begin
                        state_q   <= ST_DEAD;
                        dtimer_q  <= DT_LOAD;
                        pwm_low_q <= 1'b0;
                    end
                end
                default: begin // ST_DEAD
                    if (dtimer_q == '0) begin
                        state_q    <= state_for(demand_i);
                        pwm_high_q <= (demand_i == DEM_HIGH);
                        pwm_low_q  <= (demand_i == DEM_LOW);
                    end else begin
                        dtimer_q <= dtimer_q - TW'(1);
                    end
                end
            endcase
        end
    end

    assign pwm_high_o = pwm_high_q;
    assign pwm_low_o  = pwm_low_q;
endmodule

// File: rtl/half_bridge_driver.sv
// Multi-phase half-bridge gate driver.
//   clk_i : system clock
//   rst_i : synchronous active-high reset
//   bus   : control/gate bundle (slave side), see half_bridge_driver_if
// Owns the shared edge-aligned PWM counter, the per-phase duty/mode shadows
// (loaded at the period wrap or continuously while disabled), the demand
// decode and period_start. Each leg's dead-time FSM is a dead_time_fsm.
module half_bridge_driver
    import half_bridge_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int DUTY_WIDTH = 9,
    parameter int DEAD_TIME  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    half_bridge_driver_if.slave bus
);
    // 2^W - 2: all ones except the LSB.
    localparam logic [DUTY_WIDTH-1:0] CNT_MAX = {{(DUTY_WIDTH-1){1'b1}}, 1'b0};

    logic [DUTY_WIDTH-1:0]                  cnt_q, cnt_d;
    logic [NUM_PHASES-1:0][DUTY_WIDTH-1:0]  act_duty_q, act_duty_d;
    mode_e [NUM_PHASES-1:0]                 act_mode_q, act_mode_d;
    logic                                   period_start_q;
    logic                                   wrap, load_shadow;
    logic [NUM_PHASES-1:0]                  pwm_high, pwm_low;

    assign wrap        = bus.enable_i && (cnt_q == CNT_MAX);
    assign load_shadow = wrap || !bus.enable_i;

    always_comb begin
        cnt_d      = cnt_q + DUTY_WIDTH'(1);
        act_duty_d = act_duty_q;
        act_mode_d = act_mode_q;
        if (!bus.enable_i || wrap) cnt_d = '0;
        if (load_shadow) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                act_duty_d[i] = bus.duty_i[i*DUTY_WIDTH +: DUTY_WIDTH];
                act_mode_d[i] = mode_e'(bus.mode_i[i*2 +: 2]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q          <= '0;
            act_duty_q     <= '0;
            for (int i = 0; i < NUM_PHASES; i++) act_mode_q[i] <= MODE_COAST;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            act_duty_q     <= act_duty_d;
            act_mode_q     <= act_mode_d;
            // Only a genuine wrap pulses; leaving disable starts silently.
            period_start_q <= wrap;
        end
    end

    for (genvar i = 0; i < NUM_PHASES; i++) begin : g_leg
        demand_e demand;

        // high_z and enable act on the live inputs so they bypass shadowing.
        assign demand = decode_demand(act_mode_q[i], (cnt_q < act_duty_q[i]),
                                      bus.high_z_i[i] || !bus.enable_i);

        dead_time_fsm #(
            .DEAD_TIME (DEAD_TIME)
        ) u_fsm (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .demand_i   (demand),
            .pwm_high_o (pwm_high[i]),
            .pwm_low_o  (pwm_low[i])
        );
    end

    assign bus.pwm_high_o     = pwm_high;
    assign bus.pwm_low_o      = pwm_low;
    assign bus.period_start_o = period_start_q;
endmodule

// File: tb/tb_half_bridge_driver.sv
module tb_half_bridge_driver;
    localparam int NP   = 3;
    localparam int DW   = 4;
    localparam int DT   = 2;
    localparam int CMAX = (1 << DW) - 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    half_bridge_driver_if #(.NUM_PHASES(NP), .DUTY_WIDTH(DW)) bus ();

    half_bridge_driver #(
        .NUM_PHASES (NP),
        .DUTY_WIDTH (DW),
        .DEAD_TIME  (DT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tot = 0;
    int n_bad = 0;

    // stimulus
    bit en_in = 1'b0;
    int duty_in[NP];
    int mode_in[NP];
    bit hz_in[NP];

    // reference model: output per phase 0=off 1=high 2=low; a phase whose
    // gate dropped at edge e is held off until edge e+DT.
    int m_cnt, m_ps, edge_n;
    int m_duty[NP], m_mode[NP], m_out[NP], m_blank[NP];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int want(input int i);
        if (!en_in || hz_in[i]) return 0;
        case (m_mode[i])
            0:       return (m_cnt < m_duty[i]) ? 1 : 2;
            1:       return (m_cnt < m_duty[i]) ? 1 : 0;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        int  d[NP];
        bit  wrap;
        edge_n++;
        if (rst) begin
            m_cnt = 0; m_ps = 0;
            for (int i = 0; i < NP; i++) begin
                m_duty[i] = 0; m_mode[i] = 3; m_out[i] = 0; m_blank[i] = 0;
            end
        end else begin
            for (int i = 0; i < NP; i++) d[i] = want(i);
            for (int i = 0; i < NP; i++) begin
                if (edge_n < m_blank[i]) m_out[i] = 0;
                else if (m_out[i] != 0 && d[i] != m_out[i]) begin
                    m_out[i]   = 0;
                    m_blank[i] = edge_n + DT;
                end else m_out[i] = d[i];
            end
            wrap = en_in && (m_cnt == CMAX);
            m_ps = wrap ? 1 : 0;
            if (wrap || !en_in)
                for (int i = 0; i < NP; i++) begin
                    m_duty[i] = duty_in[i]; m_mode[i] = mode_in[i];
                end
            m_cnt = (!en_in || wrap) ? 0 : m_cnt + 1;
        end
    endtask

    // Drive inputs, advance one clock, compare against the model.
    task automatic step();
        logic [DW-1:0] dv;
        logic [1:0]    mv;
        bus.enable_i = en_in;
        for (int i = 0; i < NP; i++) begin
            dv = DW'(duty_in[i]);
            mv = 2'(mode_in[i]);
            bus.duty_i[i*DW +: DW] = dv;
            bus.mode_i[i*2 +: 2]   = mv;
            bus.high_z_i[i]        = hz_in[i];
        end
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("hi%0d", i), 32'(bus.pwm_high_o[i]), 32'(m_out[i] == 1));
            chk($sformatf("lo%0d", i), 32'(bus.pwm_low_o[i]), 32'(m_out[i] == 2));
        end
        chk("pstart", 32'(bus.period_start_o), 32'(m_ps));
    endtask

    // Count phase-0 gate cycles over one full period (cnt 0..14).
    task automatic count_period(input int chg_at, input int chg_duty,
                                output int hi, output int lo, output int ps);
        int guard;
        guard = 0; hi = 0; lo = 0; ps = 0;
        while (m_cnt != CMAX && guard < 40) begin step(); guard++; end
        if (m_cnt != CMAX) chk("align", 32'(m_cnt), 32'(CMAX));
        for (int k = 0; k <= CMAX; k++) begin
            step();
            hi += int'(bus.pwm_high_o[0]);
            lo += int'(bus.pwm_low_o[0]);
            ps += int'(bus.period_start_o);
            if (m_cnt == chg_at) duty_in[0] = chg_duty;
        end
    endtask

    task automatic set_leg0(input int mode, input int duty);
        mode_in[0] = mode; duty_in[0] = duty;
    endtask

    initial begin
        int hi, lo, ps, d;
        bus.enable_i = 1'b0; bus.duty_i = '0; bus.mode_i = '1; bus.high_z_i = '0;
        for (int i = 0; i < NP; i++) begin duty_in[i] = 0; mode_in[i] = 3; hz_in[i] = 0; end

        // reset held 3 clocks, released with enable low
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        chk("rst_hi", 32'(bus.pwm_high_o), 0);
        chk("rst_lo", 32'(bus.pwm_low_o), 0);

        // steady PWM duty 8
        set_leg0(0, 8);
        en_in = 1'b1;
        count_period(-1, 0, hi, lo, ps);
        count_period(-1, 0, hi, lo, ps);
        chk("pwm8_hi", 32'(hi), 6);
        chk("pwm8_lo", 32'(lo), 5);
        chk("pwm8_gap", 32'(CMAX + 1 - hi - lo), 4);
        chk("pwm8_ps", 32'(ps), 1);

        // reset during active PWM
        repeat (4) step();
        rst = 1'b1;
        step();
        chk("rst_run_hi", 32'(bus.pwm_high_o), 0);
        chk("rst_run_lo", 32'(bus.pwm_low_o), 0);
        rst = 1'b0;

        // extremes
        set_leg0(0, 0);
        repeat (3) count_period(-1, 0, hi, lo, ps);
        chk("d0_lo", 32'(lo), 15);
        chk("d0_hi", 32'(hi), 0);
        set_leg0(0, 15);
        repeat (2) count_period(-1, 0, hi, lo, ps);
        chk("d15_hi", 32'(hi), 15);

        // shadowing: 4 -> 10 mid-period
        set_leg0(0, 4);
        repeat (2) count_period(-1, 0, hi, lo, ps);
        count_period(6, 10, hi, lo, ps);
        chk("shadow_cur", 32'(hi), 2);
        count_period(-1, 0, hi, lo, ps);
        chk("shadow_next", 32'(hi), 8);
        chk("shadow_lo", 32'(lo), 3);

        // high_z while HIGH, held then released
        set_leg0(0, 15);
        repeat (2) count_period(-1, 0, hi, lo, ps);
        hz_in[0] = 1'b1;
        step();
        chk("hz_fall", 32'({bus.pwm_high_o[0], bus.pwm_low_o[0]}), 0);
        repeat (3) begin
            step();
            chk("hz_hold", 32'({bus.pwm_high_o[0], bus.pwm_low_o[0]}), 0);
        end
        hz_in[0] = 1'b0;
        // one-cycle pulse: measure re-drive distance from the fall edge
        repeat (4) step();
        hz_in[0] = 1'b1;
        step();
        hz_in[0] = 1'b0;
        d = 0;
        while (d < 20 && !(bus.pwm_high_o[0] || bus.pwm_low_o[0])) begin step(); d++; end
        chk("hz_redrive_ok", 32'(d >= DT && d < 20), 1);

        // modes
        set_leg0(2, 8);
        repeat (2) count_period(-1, 0, hi, lo, ps);
        chk("brake_lo", 32'(lo), 15);
        chk("brake_hi", 32'(hi), 0);
        set_leg0(1, 5);
        repeat (2) count_period(-1, 0, hi, lo, ps);
        chk("honly_lo", 32'(lo), 0);
        chk("honly_hi", 32'(hi), 5);
        set_leg0(3, 5);
        repeat (2) count_period(-1, 0, hi, lo, ps);
        chk("coast", 32'(hi + lo), 0);

        // disable with all legs driving
        for (int i = 0; i < NP; i++) begin mode_in[i] = 0; duty_in[i] = 4 + 4 * i; end
        repeat (2) count_period(-1, 0, hi, lo, ps);
        en_in = 1'b0;
        repeat (DT + 2) step();
        chk("dis_hi", 32'(bus.pwm_high_o), 0);
        chk("dis_lo", 32'(bus.pwm_low_o), 0);
        chk("dis_ps", 32'(bus.period_start_o), 0);

        // randomized traffic against the model
        en_in = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) en_in = !en_in;
            rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 39) == 0) hz_in[i] = !hz_in[i];
                if ($urandom_range(0, 9) == 0)  duty_in[i] = int'($urandom_range(0, 15));
                if ($urandom_range(0, 29) == 0) mode_in[i] = int'($urandom_range(0, 3));
            end
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
